// File: rtl/game_speed_ctrl_if.sv
// Signal bundle between the game-pace controller and its surroundings.
// master drives frame/key/collision inputs; slave is the controller itself.
interface game_speed_ctrl_if;
    logic       startOfFrame;
    logic       startKey;
    logic       pauseKey;
    logic       collision;
    logic [2:0] speed;
    logic       running;
    logic       crashed;
    logic       levelUp;
    logic       frameEnable;

    modport master (
        output startOfFrame, startKey, pauseKey, collision,
        input  speed, running, crashed, levelUp, frameEnable
    );

    modport slave (
        input  startOfFrame, startKey, pauseKey, collision,
        output speed, running, crashed, levelUp, frameEnable
    );
endinterface

// File: rtl/game_speed_ctrl.sv
// Game-pace controller: IDLE/RUN/PAUSE/CRASH FSM that ramps speed every LEVEL_FRAMES frames.
// All outputs registered (one clk after the sampled event) except frameEnable, which is combinational.
module game_speed_ctrl #(
    parameter int LEVEL_FRAMES  = 300,
    parameter int CRASH_FRAMES  = 60,
    parameter int MAX_SPEED     = 7,
    parameter int INITIAL_SPEED = 0
) (
    input  logic               clk,
    input  logic               resetN,
    game_speed_ctrl_if.slave   bus
);
    localparam logic [15:0] LEVEL_LAST = 16'(LEVEL_FRAMES - 1);
    localparam logic [15:0] CRASH_LAST = 16'(CRASH_FRAMES - 1);
    localparam logic [2:0]  SPEED_MAX  = 3'(MAX_SPEED);
    localparam logic [2:0]  SPEED_INIT = 3'(INITIAL_SPEED);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        CRASH = 2'd3
    } state_t;

    state_t      r_state;
    logic [15:0] r_frameCnt;
    logic [15:0] r_crashCnt;
    logic [2:0]  r_speed;
    logic        r_running;
    logic        r_crashed;
    logic        r_levelUp;
    logic        r_startPrev;
    logic        r_pausePrev;

    logic        w_startEdge;
    logic        w_pauseEdge;

    assign w_startEdge = bus.startKey & ~r_startPrev;
    assign w_pauseEdge = bus.pauseKey & ~r_pausePrev;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state     <= IDLE;
            r_frameCnt  <= 16'd0;
            r_crashCnt  <= 16'd0;
            r_speed     <= SPEED_INIT;
            r_running   <= 1'b0;
            r_crashed   <= 1'b0;
            r_levelUp   <= 1'b0;
            r_startPrev <= 1'b0;
            r_pausePrev <= 1'b0;
        end else begin
            r_startPrev <= bus.startKey;
            r_pausePrev <= bus.pauseKey;
            r_levelUp   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_startEdge) begin
                        r_state    <= RUN;
                        r_running  <= 1'b1;
                        r_frameCnt <= 16'd0;
                        r_speed    <= SPEED_INIT;
                    end
                end
                RUN: begin
                    // Collision outranks a same-cycle frame tick: counters stay put.
                    if (bus.collision) begin
                        r_state    <= CRASH;
                        r_crashCnt <= 16'd0;
                        r_running  <= 1'b0;
                        r_crashed  <= 1'b1;
                    end else if (w_pauseEdge) begin
                        r_state   <= PAUSE;
                        r_running <= 1'b0;
                    end else if (bus.startOfFrame) begin
                        if (r_frameCnt == LEVEL_LAST) begin
                            r_frameCnt <= 16'd0;
                            if (r_speed < SPEED_MAX) begin
                                r_speed   <= r_speed + 3'd1;
                                r_levelUp <= 1'b1;
                            end
                        end else begin
                            r_frameCnt <= r_frameCnt + 16'd1;
                        end
                    end
                end
                PAUSE: begin
                    if (w_pauseEdge) begin
                        r_state   <= RUN;
                        r_running <= 1'b1;
                    end
                end
                CRASH: begin
                    if (bus.startOfFrame) begin
                        if (r_crashCnt == CRASH_LAST) begin
                            r_state   <= IDLE;
                            r_crashed <= 1'b0;
                            r_speed   <= SPEED_INIT;
                        end else begin
                            r_crashCnt <= r_crashCnt + 16'd1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.speed       = r_speed;
    assign bus.running     = r_running;
    assign bus.crashed     = r_crashed;
    assign bus.levelUp     = r_levelUp;
    assign bus.frameEnable = bus.startOfFrame & (r_state == RUN);

endmodule

// File: tb/tb_game_speed_ctrl.sv
// Directed bench for game_speed_ctrl with short level/crash periods.
module tb_game_speed_ctrl;
    logic clk;
    logic resetN;
    game_speed_ctrl_if bus ();

    game_speed_ctrl #(
        .LEVEL_FRAMES (4),
        .CRASH_FRAMES (3),
        .MAX_SPEED    (7),
        .INITIAL_SPEED(0)
    ) dut (
        .clk   (clk),
        .resetN(resetN),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int lu_cnt   = 0;
    int lu_dbl   = 0;
    logic lu_prev = 1'b0;
    logic fe_seen;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.levelUp) lu_cnt++;
        if (bus.levelUp && lu_prev) lu_dbl++;
        lu_prev = bus.levelUp;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One-clk frame pulse followed by one idle clk; records frameEnable during the pulse.
    task automatic pulse_sof();
        @(negedge clk);
        bus.startOfFrame = 1'b1;
        #1 fe_seen = bus.frameEnable;
        @(negedge clk);
        bus.startOfFrame = 1'b0;
    endtask

    task automatic start_edge();
        @(negedge clk);
        bus.startKey = 1'b1;
        @(negedge clk);
        bus.startKey = 1'b0;
    endtask

    task automatic pause_edge();
        @(negedge clk);
        bus.pauseKey = 1'b1;
        @(negedge clk);
        bus.pauseKey = 1'b0;
    endtask

    initial begin
        resetN           = 1'b0;
        bus.startOfFrame = 1'b0;
        bus.startKey     = 1'b0;
        bus.pauseKey     = 1'b0;
        bus.collision    = 1'b0;
        fe_seen          = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_speed",   bus.speed,   0);
        chk("rst_running", bus.running, 0);
        chk("rst_crashed", bus.crashed, 0);
        chk("rst_levelup", bus.levelUp, 0);
        resetN = 1'b1;

        // Idle: frames alone must not start anything.
        for (int i = 0; i < 20; i++) begin
            pulse_sof();
            chk("idle_fe",      fe_seen,     0);
            chk("idle_speed",   bus.speed,   0);
            chk("idle_running", bus.running, 0);
        end

        // Level ramp: +1 every 4 frames, saturating at 7.
        start_edge();
        chk("start_running", bus.running, 1);
        lu_cnt = 0;
        lu_dbl = 0;
        for (int k = 1; k <= 40; k++) begin
            pulse_sof();
            chk("ramp_fe",    fe_seen,   1);
            chk("ramp_speed", bus.speed, (k / 4 > 7) ? 7 : k / 4);
            chk("ramp_lu",    bus.levelUp, ((k % 4 == 0) && (k <= 28)) ? 1 : 0);
        end
        chk("ramp_lu_count", lu_cnt, 7);
        chk("ramp_lu_width", lu_dbl, 0);

        // Crash from max speed, then timeout back to IDLE after 3 frames.
        @(negedge clk);
        bus.collision = 1'b1;
        @(negedge clk);
        bus.collision = 1'b0;
        chk("crash1_crashed", bus.crashed, 1);
        chk("crash1_running", bus.running, 0);
        chk("crash1_speed",   bus.speed,   7);
        pulse_sof();
        chk("crash1_fe", fe_seen, 0);
        pulse_sof();
        chk("crash1_hold", bus.crashed, 1);
        pulse_sof();
        chk("crash1_exit_crashed", bus.crashed, 0);
        chk("crash1_exit_speed",   bus.speed,   0);
        chk("crash1_exit_running", bus.running, 0);

        // Pause freeze at frameCnt=2; next increment 2 frames after resume.
        start_edge();
        pulse_sof();
        pulse_sof();
        pause_edge();
        chk("pause_running", bus.running, 0);
        for (int i = 0; i < 10; i++) begin
            pulse_sof();
            chk("pause_fe",    fe_seen,   0);
            chk("pause_speed", bus.speed, 0);
        end
        pause_edge();
        chk("resume_running", bus.running, 1);
        pulse_sof();
        chk("resume_f1_speed", bus.speed, 0);
        pulse_sof();
        chk("resume_f2_speed", bus.speed, 1);
        chk("resume_f2_lu",    bus.levelUp, 1);

        // Reach speed 3 with frameCnt=3, then collide on a frame tick.
        for (int i = 0; i < 11; i++) pulse_sof();
        chk("pre_sim_speed", bus.speed, 3);
        @(negedge clk);
        bus.collision    = 1'b1;
        bus.startOfFrame = 1'b1;
        #1 chk("sim_fe", bus.frameEnable, 1);
        @(negedge clk);
        bus.collision    = 1'b0;
        bus.startOfFrame = 1'b0;
        chk("sim_crashed", bus.crashed, 1);
        chk("sim_speed",   bus.speed,   3);
        chk("sim_lu",      bus.levelUp, 0);
        chk("sim_running", bus.running, 0);
        start_edge();
        chk("crash_start_ign_crashed", bus.crashed, 1);
        chk("crash_start_ign_running", bus.running, 0);
        pulse_sof();
        pulse_sof();
        chk("crash2_hold_speed", bus.speed, 3);
        pulse_sof();
        chk("crash2_exit_crashed", bus.crashed, 0);
        chk("crash2_exit_speed",   bus.speed,   0);

        // Asynchronous reset between clock edges mid-RUN.
        start_edge();
        for (int i = 0; i < 5; i++) pulse_sof();
        chk("pre_rst_speed", bus.speed, 1);
        @(posedge clk);
        #3 resetN = 1'b0;
        #1;
        chk("arst_speed",   bus.speed,   0);
        chk("arst_running", bus.running, 0);
        chk("arst_crashed", bus.crashed, 0);
        chk("arst_levelup", bus.levelUp, 0);
        @(negedge clk);
        resetN = 1'b1;
        pulse_sof();
        chk("post_rst_fe",      fe_seen,     0);
        chk("post_rst_running", bus.running, 0);

        // A held pause key yields exactly one edge.
        start_edge();
        @(negedge clk);
        bus.pauseKey = 1'b1;
        for (int i = 0; i < 3; i++) pulse_sof();
        chk("held_fe",      fe_seen,     0);
        chk("held_running", bus.running, 0);
        @(negedge clk);
        bus.pauseKey = 1'b0;
        @(negedge clk);
        chk("held_release_running", bus.running, 0);
        pause_edge();
        chk("held_resume_running", bus.running, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/game_speed_ctrl.md
# game_speed_ctrl

Game-pace controller that sits directly upstream of the scrolling-ground position generator and drives its 3-bit `speed` input. The block runs a run/pause/crash state machine from player keys and the collision detector. In RUN it raises speed by one level every `LEVEL_FRAMES` frames, saturating at `MAX_SPEED`. It also supplies a frame-move enable so downstream movers advance only while the game is running.

## Interface
- `LEVEL_FRAMES`, 300: frames per speed level (10 s at 30 Hz); legal range 1..65535.
- `CRASH_FRAMES`, 60: frames spent in CRASH before returning to IDLE; legal range 1..65535.
- `MAX_SPEED`, 7: saturation value of `speed`; legal range 0..7.
- `INITIAL_SPEED`, 0: speed loaded at reset and on game start; must be ≤ `MAX_SPEED`.

- `clk`  in  1  system clock.
- `resetN`  in  1  asynchronous, active-low reset.
- `startOfFrame`  in  1  one-clk pulse per video frame.
- `startKey`  in  1  debounced level; rising edge starts a game.
- `pauseKey`  in  1  debounced level; rising edge toggles pause.
- `collision`  in  1  level/pulse from the collision detector; sampled every clk.
- `speed`  out  3  current speed level, registered.
- `running`  out  1  registered; 1 only in RUN.
- `crashed`  out  1  registered; 1 only in CRASH.
- `levelUp`  out  1  registered one-clk pulse on each speed increment.
- `frameEnable`  out  1  combinational: `startOfFrame` AND (state == RUN).

## Operation
- Edge detect: `startKey` and `pauseKey` each have a previous-value register (reset 0). An edge is current high and previous low.
- States: IDLE (reset), RUN, PAUSE, CRASH. Also a 16-bit `frameCnt` and a 16-bit `crashCnt`.
- IDLE:
  - Outputs hold `speed`=`INITIAL_SPEED`.
  - A startKey edge moves to RUN and clears `frameCnt`=0, `speed`=`INITIAL_SPEED`.
  - All other inputs are ignored.
- RUN, with priority collision > pauseKey edge > startOfFrame tick:
  - `collision`=1 moves to CRASH, clears `crashCnt`=0 and freezes `speed`.
  - A pauseKey edge moves to PAUSE; `frameCnt` and `speed` are frozen.
  - On a `startOfFrame` tick with `frameCnt`==`LEVEL_FRAMES`-1: set `frameCnt`=0. If `speed`<`MAX_SPEED`, then `speed`+1 and `levelUp`=1 next cycle. At `MAX_SPEED` there is no increment and no pulse.
  - On a `startOfFrame` tick otherwise: `frameCnt`+1.
- PAUSE:
  - A pauseKey edge returns to RUN; counters resume from their frozen values.
  - `collision`, startKey and `startOfFrame` are ignored.
- CRASH:
  - On each `startOfFrame`: if `crashCnt`==`CRASH_FRAMES`-1, go to IDLE and load `speed`=`INITIAL_SPEED`; else `crashCnt`+1.
  - Keys and `collision` are ignored.
- startKey edges in RUN, PAUSE and CRASH are ignored. There is no restart mid-game.

## Timing
- Reset (asynchronous): state=IDLE, `speed`=`INITIAL_SPEED`, `running`=0, `crashed`=0, `levelUp`=0, `frameCnt`=0, `crashCnt`=0, edge registers=0.
- All state, counter and output updates take effect on the clk edge that samples the event; they are visible the following cycle.
- `levelUp` is high exactly one clk, the cycle after the incrementing `startOfFrame`.
- `frameEnable` is same-cycle combinational. It is 0 in the frame pulse that causes RUN→PAUSE/CRASH if the transition is registered earlier, and follows the current registered state otherwise.
- Simultaneous `collision` and `startOfFrame` in RUN: CRASH wins and `frameCnt`/`speed` do not update. `frameEnable` is still 1 in that cycle, because the state is still RUN.
- Reset asserted mid-game returns to IDLE immediately; no pulse is emitted on release.
- A held key produces exactly one edge; the key must fall before another edge can occur.

## Test plan
- Reset then idle (`LEVEL_FRAMES`=4): 20 `startOfFrame` pulses with no keys -> `speed`=0, `running`=0, `frameEnable`=0 throughout.
- Level ramp (`LEVEL_FRAMES`=4, `MAX_SPEED`=7): startKey edge, then 40 frames -> `speed` steps 0→1 at frame 4, →2 at frame 8, … →7 at frame 28. There are 7 single-clk `levelUp` pulses and `speed` stays 7 through frame 40.
- Pause freeze: in RUN at `frameCnt`=2, pauseKey edge, 10 frames, pauseKey edge -> no speed change and `frameEnable`=0 while paused. The next increment lands 2 frames after resume.
- Crash timeout (`CRASH_FRAMES`=3): speed 3, `collision` pulse -> `crashed`=1 and `speed` held at 3. After 3 frames: IDLE, `speed`=0, `crashed`=0.
- Simultaneous collision + startOfFrame at `frameCnt`=3 -> CRASH with `speed` unchanged and no `levelUp`. A startKey edge during CRASH is ignored.
- Asynchronous reset mid-RUN between clk edges -> all outputs return to reset values immediately, state=IDLE.
